// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit sequencer: FSM encoding, digit width
// and the code written into a result nibble when the source digit is not BCD.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] INVALID_CODE = 4'hF;
  localparam logic [DIGIT_W-1:0] MAX_BCD = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_digit_check.sv
// Flags a single nibble that is not a legal BCD digit (value above 9).
module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic               invalid
);

  assign invalid = (digit > MAX_BCD);

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Walks a latched BCD word one digit at a time through an external
// combinational converter and reassembles the converted word.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for in_valid; conv_din=0
//   CONV  | presenting digit[idx] to the converter, capturing one per clock
//   DONE  | out_valid=1, result held until out_ready
module bcd_digit_sequencer
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIGIT_W*NDIGITS-1:0] in_data,
  output logic [DIGIT_W-1:0]         conv_din,
  input  logic [DIGIT_W-1:0]         conv_dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIGIT_W*NDIGITS-1:0] out_data,
  output logic [NDIGITS-1:0]         out_err
);

  localparam int W     = DIGIT_W * NDIGITS;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

  bcd_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [W-1:0]         data_q;
  logic [W-1:0]         result_q;
  logic [NDIGITS-1:0]   err_q;
  logic [DIGIT_W-1:0]   cur_digit;
  logic                 digit_bad;
  logic                 accept;

  // The latched word is the only digit source, so upstream changes after
  // acceptance cannot reach the converter.
  assign cur_digit = data_q[idx_q*DIGIT_W +: DIGIT_W];
  assign accept    = (state_q == IDLE) && in_valid;

  bcd_digit_check u_digit_check (
    .digit   (cur_digit),
    .invalid (digit_bad)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/converter outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    conv_din  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CONV;
      end
      CONV: begin
        conv_din = cur_digit;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word latch, digit index and per-digit result capture. Non-BCD digits
  // bypass the converter result entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      err_q    <= '0;
    end else if (accept) begin
      idx_q    <= '0;
      data_q   <= in_data;
      result_q <= '0;
      err_q    <= '0;
    end else if (state_q == CONV) begin
      if (digit_bad) begin
        result_q[idx_q*DIGIT_W +: DIGIT_W] <= INVALID_CODE;
        err_q[idx_q]                       <= 1'b1;
      end else begin
        result_q[idx_q*DIGIT_W +: DIGIT_W] <= conv_dout;
      end
      // Index parks on the last digit rather than wrapping.
      if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
    end
  end

  assign out_data = result_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Self-checking bench for bcd_digit_sequencer with an excess-3 converter model.
module tb_bcd_digit_sequencer;

  localparam int ND = 4;
  localparam int W  = 4 * ND;

  typedef struct {
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic [ND-1:0] err;
  } vec_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [ND-1:0] err;
  } sb_item_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    conv_din;
  logic [3:0]    conv_dout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [ND-1:0] out_err;

  int       n_vec;
  int       n_miss;
  int       n_out;
  int       cyc;
  sb_item_t sb_q[$];
  vec_t     vecs[8];

  bcd_digit_sequencer #(.NDIGITS(ND)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .conv_din  (conv_din),
    .conv_dout (conv_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // External converter: excess-3.
  assign conv_dout = conv_din + 4'd3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: event did not occur within its budget (t=%0t)", nm, $time);
  endtask

  function automatic sb_item_t model(input logic [W-1:0] w);
    sb_item_t   r;
    logic [3:0] nib;
    r.data = '0;
    r.err  = '0;
    for (int i = 0; i < ND; i++) begin
      nib = w[i*4 +: 4];
      if (nib > 4'd9) begin
        r.data[i*4 +: 4] = 4'hF;
        r.err[i]         = 1'b1;
      end else begin
        r.data[i*4 +: 4] = nib + 4'd3;
      end
    end
    return r;
  endfunction

  // Output side of the scoreboard: compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output (t=%0t)", out_data, $time);
      end else begin
        sb_item_t e;
        e = sb_q.pop_front();
        check("sb_out_data", 32'(out_data), 32'(e.data));
        check("sb_out_err", 32'(out_err), 32'(e.err));
        n_out++;
      end
    end
  end

  // Present a word, wait for acceptance, push its expectation, then scramble
  // the input bus so a design that rereads in_data is caught.
  task automatic accept_word(input logic [W-1:0] w, input logic [W-1:0] ed, input logic [ND-1:0] ee);
    bit ok;
    sb_item_t it;
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
    end else begin
      it.data = ed;
      it.err  = ee;
      sb_q.push_back(it);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  // Follow a word through CONV (digit order on conv_din, in_ready low) and
  // check the handshake edge lands NDIGITS+1 cycles after the accept edge.
  task automatic watch_word(input logic [W-1:0] w);
    int cnt;
    bit ok;
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      if (cnt < ND) check("conv_din_digit", 32'(conv_din), 32'(w[cnt*4 +: 4]));
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cnt++;
    end
    if (!ok) begin
      fail_now("out_valid_timeout");
    end else begin
      check("handshake_offset", 32'(cnt + 1), 32'(ND + 1));
      check("conv_din_done", 32'(conv_din), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("in_ready_after_hs", 32'(in_ready), 32'd1);
      check("out_valid_after_hs", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(nm);
  endtask

  initial begin
    logic [W-1:0] words[6];
    int prev;
    int k;
    int out_base;
    bit ok;
    sb_item_t m;

    vecs[0] = '{16'h0925, 16'h3C58, 4'b0000};
    vecs[1] = '{16'hA1B3, 16'hF4F6, 4'b1010};
    vecs[2] = '{16'h1234, 16'h4567, 4'b0000};
    vecs[3] = '{16'h0000, 16'h3333, 4'b0000};
    vecs[4] = '{16'h9999, 16'hCCCC, 4'b0000};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 4'b1111};
    vecs[6] = '{16'h9A09, 16'hCF3C, 4'b0100};
    vecs[7] = '{16'h5678, 16'h89AB, 4'b0000};

    words[0] = 16'h0925;
    words[1] = 16'hA1B3;
    words[2] = 16'h1234;
    words[3] = 16'h9876;
    words[4] = 16'h0000;
    words[5] = 16'hFFFF;

    n_vec = 0; n_miss = 0; n_out = 0; cyc = 0;
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset values, observed before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_conv_din", 32'(conv_din), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_conv_din", 32'(conv_din), 32'd0);
    @(posedge clk); #1;

    // Table-driven words with the downstream always ready.
    foreach (vecs[i]) begin
      accept_word(vecs[i].din, vecs[i].dout, vecs[i].err);
      watch_word(vecs[i].din);
    end
    drain("table_drain");

    // Backpressure: result must hold for 10 cycles with the input blocked.
    out_ready = 1'b0;
    accept_word(16'h4321, 16'h7654, 4'b0000);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) fail_now("bp_valid_timeout");
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_data", 32'(out_data), 32'h7654);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Reset during the second CONV cycle discards the word.
    m = model(16'h5555);
    accept_word(16'h5555, m.data, m.err);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_conv_din", 32'(conv_din), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_err", 32'(out_err), 32'd0);
    sb_q.delete();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(out_valid), 32'd0);
      check("midrst_idle_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    accept_word(16'h1234, 16'h4567, 4'b0000);
    watch_word(16'h1234);
    drain("midrst_drain");

    // Back-to-back words: in_valid held high, downstream always ready.
    out_base = n_out;
    prev = 0;
    k = 0;
    in_data  = words[0];
    in_valid = 1'b1;
    for (int i = 0; i < 200 && k < 6; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(words[k]));
        if (k > 0) check("b2b_interval", 32'(cyc - prev), 32'(ND + 2));
        prev = cyc;
        k++;
      end
      @(posedge clk); #1;
      if (k < 6) in_data = words[k];
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    if (k < 6) fail_now("b2b_accept_timeout");
    drain("b2b_drain");
    check("b2b_word_count", 32'(n_out - out_base), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_digit_sequencer.md
BCD_DIGIT_SEQUENCER -- requirements
Module: bcd_digit_sequencer

Interface
REQ-001 The block SHALL have parameter NDIGITS, default 4, giving the number of BCD digits per word (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, 4*NDIGITS bits: packed BCD word, digit 0 in bits [3:0].
REQ-007 The block SHALL have port conv_din, output, 4 bits: digit driven to the external combinational BCD converter (bit3 drives a, bit0 drives d).
REQ-008 The block SHALL have port conv_dout, input, 4 bits: converter result (bit3 is e, bit0 is h).
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result word is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port out_data, output, 4*NDIGITS bits: converted word, packed like in_data.
REQ-012 The block SHALL have port out_err, output, NDIGITS bits: bit i is set when digit i was >9.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; an in_valid&&in_ready cycle SHALL latch in_data, clear the result and error registers, set the digit index to 0 and move the FSM to CONV.
REQ-015 In CONV, conv_din SHALL present the latched digit[idx]; at each clock edge the block SHALL capture conv_dout into result nibble idx, then increment idx.
REQ-016 If digit[idx] > 9, the block SHALL store 4'hF in result nibble idx and set out_err[idx], and SHALL NOT use conv_dout for that digit.
REQ-017 After capturing digit NDIGITS-1, the FSM SHALL go to DONE; the first out_valid SHALL therefore be NDIGITS+1 cycles after the accept edge.
REQ-018 In DONE, out_valid SHALL be 1, and out_data/out_err SHALL be held stable until out_valid&&out_ready.
REQ-019 The handshake cycle (out_valid&&out_ready) SHALL return the FSM to IDLE; in_ready SHALL be 0 in CONV and DONE, so no new word is accepted in the cycle the handshake completes.
REQ-020 In IDLE and DONE, conv_din SHALL be 4'h0.
REQ-021 The idx counter SHALL be ceil(log2(NDIGITS)) bits wide (minimum 1) and SHALL NOT wrap during CONV.
REQ-022 A change on in_data or in_valid after acceptance SHALL NOT affect the word in flight.

Reset
REQ-023 On rst_n low, the state SHALL go to IDLE and idx, the data latch, out_data and out_err SHALL be cleared to 0, with out_valid=0 and conv_din=0, regardless of the clock.
REQ-024 A reset asserted mid-CONV or in DONE SHALL discard the word with no out_valid; after reset release, in_ready SHALL be 1 from the first cycle.

Structure
REQ-025 State encodings (IDLE, CONV, DONE), the digit width constant (4) and the invalid-digit code (4'hF) SHALL live in a shared package bcd_pkg.
REQ-026 The converter SHALL stay outside this block and connect through conv_din/conv_dout; one internal sub-module, bcd_digit_check (combinational, flags a digit >9), is permitted.

Verification
REQ-027 Reset value check: assert rst_n low -> out_valid=0, in_ready=1, conv_din=0, out_data=0, out_err=0.
REQ-028 Nominal word: in_data=16'h0925 with the converter modelled as excess-3 -> out_data=16'h3C58, out_err=4'b0000, out_valid at accept+5 cycles.
REQ-029 Invalid digits: in_data=16'hA1B3 -> out_data=16'hF4F6, out_err=4'b1010.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable and in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
REQ-031 Mid-operation reset: pulse rst_n low during the 2nd CONV cycle -> no out_valid, then word 16'h1234 after release -> out_data=16'h4567.
REQ-032 Back-to-back words: hold in_valid=1 with out_ready=1 -> a new word is accepted every NDIGITS+2 cycles and no word is dropped or duplicated.
